spi_mstr_arb: RTL and testbench
===============================

Name: spi_mstr_arb

Overview:
- Arbitrates one shared 16-bit SPI master (SPI_mstr16) between two requesters: port 0 is the A2D interface, port 1 is the inertial-sensor interface.
- Queues single-cycle requests, grants round-robin, launches each transaction and returns the read data.
- Supports locked back-to-back transaction pairs, such as the A2D channel-select/readback pair.
- Sits between the requesters and the SPI master. External logic uses `sel` to route SS_n to the owning slave.

Parameters:
- LOCK_WIN, 8: clocks the owner keeps exclusive ownership after a locked transaction completes.
- WDOG_CYC, 1023: BUSY-state timeout in clocks; used only when SPI_ARB_WDOG_EN is defined.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset
- req0  in  1  one-cycle request pulse, port 0
- lock0  in  1  sampled with req0; 1 means a follow-up transaction will come
- cmd0  in  16  command, valid when req0=1
- done0  out  1  one-cycle pulse when a port-0 transaction ends
- req1, lock1, cmd1, done1  same as port 0, for port 1
- rd_data  out  16  data from the last completed transaction
- spi_wrt  out  1  one-cycle launch pulse to the SPI master
- spi_cmd  out  16  command to the SPI master
- spi_done  in  1  transaction-complete pulse from the SPI master
- spi_rd_data  in  16  read data from the SPI master
- sel  out  1  current or last owner (0 = port 0, 1 = port 1)
- err  out  1  one-cycle watchdog-abort pulse

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - state = IDLE
  - pend0, pend1, lockbuf0, lockbuf1 = 0
  - cmdbuf0, cmdbuf1 = 0
  - rr_ptr = 0 (port 0 has priority)
  - done0, done1, spi_wrt, err, sel = 0
  - rd_data = 16'h0000
  - All counters = 0
- Request capture:
  - A reqX pulse while pendX=0 sets pendX at the next edge and latches cmdX into cmdbufX and lockX into lockbufX.
  - A reqX pulse while pendX=1 is dropped. The buffer is unchanged and no error is raised.
- States: IDLE, LAUNCH, BUSY, HOLD. The state register is the only one with asynchronous reset behaviour on state; all outputs are registered.
- IDLE:
  - If only one pend bit is set, that port wins.
  - If both are set, the port indicated by rr_ptr wins.
  - On a win: owner ← winner, sel ← winner, clear the winner's pend bit, go to LAUNCH.
- LAUNCH:
  - spi_wrt=1 for exactly this cycle.
  - spi_cmd = cmdbuf[owner], held stable until the transaction ends.
  - Go to BUSY.
- BUSY:
  - Wait for spi_done.
  - On spi_done: rd_data ← spi_rd_data and done[owner] pulses in the next cycle.
  - If lockbuf[owner]=1, go to HOLD and load hold_cnt=LOCK_WIN.
  - Otherwise, rr_ptr ← ~owner and go to IDLE.
- HOLD:
  - If pend[owner]=1, clear it and go to LAUNCH. The other port is ignored even if pending.
  - Otherwise decrement hold_cnt.
  - When hold_cnt reaches 0, rr_ptr ← ~owner and go to IDLE.
- Latency: a req at edge N on an idle arbiter gives pend at N+1, LAUNCH at N+2 with spi_wrt=1, and doneX one cycle after spi_done.
- Simultaneous events:
  - req and done for the same port in the same cycle: the req is captured; the done is still delivered.
  - spi_done outside BUSY is ignored.
- A port may not be granted twice in a row unless it held the lock or the other port's pend=0.
- A reset mid-transaction returns to IDLE immediately. Any SPI master activity in flight is its own concern.

Optional Feature:
- SPI_ARB_WDOG_EN defined:
  - A BUSY counter starts at 0 in LAUNCH.
  - If it reaches WDOG_CYC without spi_done, the transaction is aborted: rd_data ← 16'hFFFF, done[owner] and err pulse together, lock is discarded, rr_ptr ← ~owner, state → IDLE.
  - A spi_done arriving in the same cycle as the timeout wins, with no err.
- SPI_ARB_WDOG_EN not defined:
  - err is tied to 0 and no counter is built.
  - BUSY waits indefinitely.

Test Plan:
- req0 with cmd0=16'h2000 on an idle arbiter; spi_done 20 clocks after spi_wrt with spi_rd_data=16'h0ABC. Required: spi_wrt 2 clocks after req0 with spi_cmd=16'h2000; done0 one clock after spi_done; rd_data=16'h0ABC; sel=0; done1 never asserts.
- req0 and req1 in the same cycle after reset. Required: port 0 served first; port 1 launches 2 clocks after done0's spi_done; sel=1 during the second transaction; rr_ptr then favours port 0.
- req0 with lock0=1 and req1 pending; port 0 re-requests 3 clocks after done0. Required: port 0's second transaction launches before port 1. Repeat with no re-request: port 1 launches after LOCK_WIN=8 idle clocks.
- Second req1 pulse (cmd1=16'hFFFF) while pend1=1 and cmd1=16'h8F00 is buffered. Required: only one transaction, with spi_cmd=16'h8F00.
- SPI_ARB_WDOG_EN with WDOG_CYC=16; spi_done withheld. Required: on clock 16 of BUSY, err and done0 pulse, rd_data=16'hFFFF, state returns to IDLE, and the next pending request is served. Without the macro, no timeout and err stays 0.
- rst_n asserted during BUSY. Required: all outputs return to reset values asynchronously; a spi_done after reset is ignored with no done pulse.

Source files
------------

// File: rtl/spi_mstr_arb.sv
// rtl/spi_mstr_arb.sv - round-robin arbiter sharing one 16-bit SPI master between two ports
// Optional BUSY watchdog enabled by defining SPI_ARB_WDOG_EN.
module spi_mstr_arb #(
  parameter int LOCK_WIN = 8,
  parameter int WDOG_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        lock0,
  input  logic [15:0] cmd0,
  output logic        done0,
  input  logic        req1,
  input  logic        lock1,
  input  logic [15:0] cmd1,
  output logic        done1,
  output logic [15:0] rd_data,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic        sel,
  output logic        err
);

  localparam int HW = $clog2(LOCK_WIN + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, HOLD} state_t;

  state_t        state, state_nxt;
  logic          pend0, pend1, lockbuf0, lockbuf1;
  logic [15:0]   cmdbuf0, cmdbuf1;
  logic          rr_ptr, rr_nxt;
  logic          owner, owner_nxt;
  logic          cur_lock, cur_lock_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          clr0, clr1;
  logic          sel_nxt, spi_wrt_nxt, done0_nxt, done1_nxt, err_nxt;
  logic [15:0]   spi_cmd_nxt, rd_nxt;
  logic          own_pend, own_lockbuf;
  logic [15:0]   own_cmdbuf;

  assign own_pend    = owner ? pend1 : pend0;
  assign own_lockbuf = owner ? lockbuf1 : lockbuf0;
  assign own_cmdbuf  = owner ? cmdbuf1 : cmdbuf0;

`ifdef SPI_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);
  logic [WW-1:0] wd_cnt, wd_nxt;
`else
  logic [31:0] unused_wdog_cyc;
  assign unused_wdog_cyc = WDOG_CYC;
`endif

  always_comb begin
    state_nxt    = state;
    rr_nxt       = rr_ptr;
    owner_nxt    = owner;
    cur_lock_nxt = cur_lock;
    hold_nxt     = hold_cnt;
    clr0         = 1'b0;
    clr1         = 1'b0;
    sel_nxt      = sel;
    spi_wrt_nxt  = 1'b0;
    spi_cmd_nxt  = spi_cmd;
    done0_nxt    = 1'b0;
    done1_nxt    = 1'b0;
    err_nxt      = 1'b0;
    rd_nxt       = rd_data;
`ifdef SPI_ARB_WDOG_EN
    wd_nxt       = wd_cnt;
`endif
    case (state)
      IDLE: begin
        if (pend0 && (!pend1 || !rr_ptr)) begin
          owner_nxt    = 1'b0;
          sel_nxt      = 1'b0;
          clr0         = 1'b1;
          cur_lock_nxt = lockbuf0;
          spi_cmd_nxt  = cmdbuf0;
          spi_wrt_nxt  = 1'b1;
          state_nxt    = LAUNCH;
        end else if (pend1) begin
          owner_nxt    = 1'b1;
          sel_nxt      = 1'b1;
          clr1         = 1'b1;
          cur_lock_nxt = lockbuf1;
          spi_cmd_nxt  = cmdbuf1;
          spi_wrt_nxt  = 1'b1;
          state_nxt    = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = BUSY;
`ifdef SPI_ARB_WDOG_EN
        wd_nxt    = '0;
`endif
      end
      BUSY: begin
        if (spi_done) begin
          rd_nxt    = spi_rd_data;
          done0_nxt = ~owner;
          done1_nxt = owner;
          if (cur_lock) begin
            hold_nxt  = HW'(LOCK_WIN);
            state_nxt = HOLD;
          end else begin
            rr_nxt    = ~owner;
            state_nxt = IDLE;
          end
        end
`ifdef SPI_ARB_WDOG_EN
        else if (wd_cnt == WW'(WDOG_CYC - 1)) begin
          rd_nxt       = 16'hFFFF;
          done0_nxt    = ~owner;
          done1_nxt    = owner;
          err_nxt      = 1'b1;
          cur_lock_nxt = 1'b0;
          rr_nxt       = ~owner;
          state_nxt    = IDLE;
        end else begin
          wd_nxt = wd_cnt + WW'(1);
        end
`endif
      end
      HOLD: begin
        // Only the owner may re-enter; the other port waits out the window.
        if (own_pend) begin
          clr0         = ~owner;
          clr1         = owner;
          cur_lock_nxt = own_lockbuf;
          spi_cmd_nxt  = own_cmdbuf;
          spi_wrt_nxt  = 1'b1;
          state_nxt    = LAUNCH;
        end else if (hold_cnt <= HW'(1)) begin
          hold_nxt  = '0;
          rr_nxt    = ~owner;
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold_cnt - HW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend0    <= 1'b0;
      pend1    <= 1'b0;
      lockbuf0 <= 1'b0;
      lockbuf1 <= 1'b0;
      cmdbuf0  <= 16'h0000;
      cmdbuf1  <= 16'h0000;
      rr_ptr   <= 1'b0;
      owner    <= 1'b0;
      cur_lock <= 1'b0;
      hold_cnt <= '0;
      sel      <= 1'b0;
      spi_wrt  <= 1'b0;
      spi_cmd  <= 16'h0000;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err      <= 1'b0;
      rd_data  <= 16'h0000;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      owner    <= owner_nxt;
      cur_lock <= cur_lock_nxt;
      hold_cnt <= hold_nxt;
      sel      <= sel_nxt;
      spi_wrt  <= spi_wrt_nxt;
      spi_cmd  <= spi_cmd_nxt;
      done0    <= done0_nxt;
      done1    <= done1_nxt;
      err      <= err_nxt;
      rd_data  <= rd_nxt;
      // A request arriving while its port is already pending is dropped.
      if (req0 && !pend0) begin
        pend0    <= 1'b1;
        cmdbuf0  <= cmd0;
        lockbuf0 <= lock0;
      end else if (clr0) begin
        pend0 <= 1'b0;
      end
      if (req1 && !pend1) begin
        pend1    <= 1'b1;
        cmdbuf1  <= cmd1;
        lockbuf1 <= lock1;
      end else if (clr1) begin
        pend1 <= 1'b0;
      end
    end
  end

`ifdef SPI_ARB_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_cnt <= '0;
    else        wd_cnt <= wd_nxt;
  end
`endif

endmodule

// File: tb/tb_spi_mstr_arb.sv
// tb/tb_spi_mstr_arb.sv - scoreboard bench for spi_mstr_arb
module tb_spi_mstr_arb;

  localparam int WDOG = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
  logic [15:0] cmd0 = 16'h0, cmd1 = 16'h0;
  logic        done0, done1, spi_wrt, sel, err;
  logic [15:0] rd_data, spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd_data;

  spi_mstr_arb #(.LOCK_WIN(8), .WDOG_CYC(WDOG)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .lock0(lock0), .cmd0(cmd0), .done0(done0),
    .req1(req1), .lock1(lock1), .cmd1(cmd1), .done1(done1),
    .rd_data(rd_data), .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
    .spi_done(spi_done), .spi_rd_data(spi_rd_data),
    .sel(sel), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic port; logic [15:0] cmd; } launch_t;
  typedef struct { logic port; logic [15:0] data; logic err; } done_t;

  launch_t     exp_launch[$];
  done_t       exp_done[$];
  logic [15:0] slave_rd_q[$];
  launch_t     lq;
  done_t       dq;

  int n_cmp = 0, n_bad = 0;
  int wrt_cyc[2], done_cyc[2];
  int sdone_cyc = 0, done_cnt = 0, err_seen = 0;
  int slave_dly = 20;
  bit slave_hold = 1'b0;
  int kick_req = 0, kick_ack = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not expected / not seen", name);
  endtask

  // SPI master model: completes each launch after slave_dly clocks
  task automatic fire(input int d);
    repeat (d) @(posedge clk);
    #1;
    spi_rd_data = (slave_rd_q.size() > 0) ? slave_rd_q.pop_front() : 16'h5A5A;
    spi_done = 1'b1;
    @(posedge clk);
    #1 spi_done = 1'b0;
  endtask

  initial begin
    spi_done = 1'b0;
    spi_rd_data = 16'h0;
    forever begin
      @(negedge clk);
      if (rst_n && spi_wrt && !slave_hold) fire(slave_dly);
      else if (kick_req != kick_ack) begin
        kick_ack = kick_req;
        fire(1);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a launch or completion
  always @(negedge clk) begin
    if (rst_n) begin
      if (spi_done) sdone_cyc = cyc;
      if (err) err_seen++;
      if (spi_wrt) begin
        wrt_cyc[sel] = cyc;
        if (exp_launch.size() == 0) flag("unexpected_launch");
        else begin
          lq = exp_launch.pop_front();
          check("launch_cmd", {16'h0, spi_cmd}, {16'h0, lq.cmd});
          check("launch_sel", {31'h0, sel}, {31'h0, lq.port});
        end
      end
      if (done0 && done1) flag("both_done");
      if (done0 || done1) begin
        done_cnt++;
        done_cyc[done1] = cyc;
        if (exp_done.size() == 0) flag("unexpected_done");
        else begin
          dq = exp_done.pop_front();
          check("done_port", {31'h0, done1}, {31'h0, dq.port});
          check("done_rd_data", {16'h0, rd_data}, {16'h0, dq.data});
          check("done_err", {31'h0, err}, {31'h0, dq.err});
          if (!dq.err) check("done_latency", cyc - sdone_cyc, 1);
        end
      end else if (err) flag("err_without_done");
    end
  end

  task automatic expect_txn(input logic p, input logic [15:0] c, input logic [15:0] d);
    exp_launch.push_back('{p, c});
    slave_rd_q.push_back(d);
    exp_done.push_back('{p, d, 1'b0});
  endtask

  task automatic pulse_req(input logic p, input logic [15:0] c, input logic l);
    @(posedge clk);
    #1;
    if (p) begin req1 = 1'b1; cmd1 = c; lock1 = l; end
    else   begin req0 = 1'b1; cmd0 = c; lock0 = l; end
    @(posedge clk);
    #1 req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
  endtask

  task automatic pulse_both(input logic [15:0] c0, input logic [15:0] c1);
    @(posedge clk);
    #1 req0 = 1'b1; cmd0 = c0; req1 = 1'b1; cmd1 = c1;
    @(posedge clk);
    #1 req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_launch.size() != 0 || exp_done.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      flag(name);
      exp_launch.delete();
      exp_done.delete();
    end
    repeat (12) @(posedge clk);
  endtask

  task automatic wait_done(input logic p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p ? done1 : done0) && n < 1000);
    if (n >= 1000) flag("wait_done_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_spi_wrt"}, {31'h0, spi_wrt}, 0);
    check({tag, "_spi_cmd"}, {16'h0, spi_cmd}, 0);
    check({tag, "_sel"}, {31'h0, sel}, 0);
    check({tag, "_rd_data"}, {16'h0, rd_data}, 0);
    check({tag, "_done0"}, {31'h0, done0}, 0);
    check({tag, "_done1"}, {31'h0, done1}, 0);
    check({tag, "_err"}, {31'h0, err}, 0);
  endtask

  initial begin
    int req_cyc, n, dc;
    #12 check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Simultaneous requests after reset: port 0 first, port 1 two clocks after spi_done
    expect_txn(1'b0, 16'h1000, 16'h1111);
    expect_txn(1'b1, 16'h1001, 16'h2222);
    pulse_both(16'h1000, 16'h1001);
    drain("pair1_drain");
    check("pair1_gap", wrt_cyc[1] - done_cyc[0], 1);

    // Port 1 was served last, so port 0 wins again
    expect_txn(1'b0, 16'h1100, 16'h3333);
    expect_txn(1'b1, 16'h1101, 16'h4444);
    pulse_both(16'h1100, 16'h1101);
    drain("pair2_drain");

    // Single request on an idle arbiter
    expect_txn(1'b0, 16'h2000, 16'h0ABC);
    @(posedge clk);
    #1 req0 = 1'b1; cmd0 = 16'h2000; req_cyc = cyc;
    @(posedge clk);
    #1 req0 = 1'b0;
    drain("single_drain");
    check("single_wrt_latency", wrt_cyc[0] - req_cyc, 2);
    check("single_rd_data", {16'h0, rd_data}, 32'h0ABC);
    check("single_sel", {31'h0, sel}, 0);

    // Port 0 was served last, so port 1 wins the next tie
    expect_txn(1'b1, 16'h3001, 16'h5555);
    expect_txn(1'b0, 16'h3000, 16'h6666);
    pulse_both(16'h3000, 16'h3001);
    drain("rr_drain");

    // Locked pair: port 0 re-requests inside the window and beats pending port 1
    expect_txn(1'b0, 16'hA000, 16'h0101);
    expect_txn(1'b0, 16'hA001, 16'h0202);
    expect_txn(1'b1, 16'hB000, 16'h0303);
    pulse_req(1'b0, 16'hA000, 1'b1);
    pulse_req(1'b1, 16'hB000, 1'b0);
    wait_done(1'b0);
    repeat (2) @(posedge clk);
    pulse_req(1'b0, 16'hA001, 1'b0);
    drain("lock_a_drain");

    // Locked with no re-request: port 1 launches after the hold window expires
    expect_txn(1'b0, 16'hC000, 16'h0404);
    expect_txn(1'b1, 16'hD000, 16'h0505);
    pulse_req(1'b0, 16'hC000, 1'b1);
    pulse_req(1'b1, 16'hD000, 1'b0);
    drain("lock_b_drain");
    check("lock_b_window", wrt_cyc[1] - done_cyc[0], 9);

    // Second req1 while pend1 is set is dropped
    expect_txn(1'b0, 16'h4000, 16'h0606);
    expect_txn(1'b1, 16'h8F00, 16'h0707);
    pulse_req(1'b0, 16'h4000, 1'b0);
    pulse_req(1'b1, 16'h8F00, 1'b0);
    repeat (3) @(posedge clk);
    pulse_req(1'b1, 16'hFFFF, 1'b0);
    drain("drop_drain");

`ifdef SPI_ARB_WDOG_EN
    slave_hold = 1'b1;
    exp_launch.push_back('{1'b0, 16'hE000});
    exp_done.push_back('{1'b0, 16'hFFFF, 1'b1});
    expect_txn(1'b1, 16'hE100, 16'h0808);
    pulse_req(1'b0, 16'hE000, 1'b0);
    pulse_req(1'b1, 16'hE100, 1'b0);
    wait_done(1'b0);
    slave_hold = 1'b0;
    drain("wdog_drain");
    check("wdog_abort_time", done_cyc[0] - wrt_cyc[0], WDOG + 1);
    check("wdog_err_count", err_seen, 1);
`else
    slave_hold = 1'b1;
    exp_launch.push_back('{1'b0, 16'hE000});
    dc = done_cnt;
    pulse_req(1'b0, 16'hE000, 1'b0);
    repeat (3 * WDOG + 10) @(posedge clk);
    check("nowdog_no_done", done_cnt - dc, 0);
    check("nowdog_no_err", err_seen, 0);
    slave_rd_q.push_back(16'h1234);
    exp_done.push_back('{1'b0, 16'h1234, 1'b0});
    slave_hold = 1'b0;
    kick_req++;
    drain("nowdog_drain");
`endif

    // Reset during BUSY, then a stale spi_done must be ignored
    slave_dly = 10;
    exp_launch.push_back('{1'b1, 16'h7777});
    pulse_req(1'b1, 16'h7777, 1'b0);
    n = 0;
    while (!spi_wrt && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) flag("reset_launch_timeout");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    dc = done_cnt;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("post_reset_no_done", done_cnt - dc, 0);
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    flag("global_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
